// File: rtl/tlp_xcvr_pkg.sv
// tlp_xcvr_pkg: shared types for the PCIe endpoint TLP transmit/receive path.
//   - Action:         action word handed from tlp_recv to tlp_send
//   - Completion0/1:  CplD header beats (3DW header, 64-bit beats)
//   - RdReq0/1:       MRd header beats (3DW header, 64-bit beats)
//   - fmt/typ codes and the DMA read size
package tlp_xcvr_pkg;

  typedef logic [15:0] BusID;
  typedef logic [3:0]  ExtChan;

  // Two-bit kind field; codes other than these two are legal on the wire
  // and are silently dropped by the transmitter.
  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1
  } ActionKind;

  typedef struct packed {
    ActionKind   kind;
    ExtChan      chan;
    logic [31:0] data;
    BusID        reqID;
    logic [7:0]  tag;
  } Action;

  localparam logic [2:0] FMT_H3DW_NODATA   = 3'b000;
  localparam logic [2:0] FMT_H3DW_WITHDATA = 3'b010;
  localparam logic [4:0] TYP_MEM_RW_REQ    = 5'b00000;
  localparam logic [4:0] TYP_COMPLETION    = 5'b01010;

  // One DMA read fetches 16 quadwords (128 bytes) = 32 dwords.
  localparam int DMA_QWS = 16;
  localparam logic [9:0] DMA_LEN_DW = 10'(DMA_QWS * 2);

  // Header DW0, common to every TLP we emit (TC, attributes, TD, EP all 0).
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic [7:0] rsvd_tc;
    logic [5:0] rsvd_attr;
    logic [9:0] length;
  } HdrDw0;

  typedef struct packed {
    BusID        completerID;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byteCount;
    HdrDw0       dw0;
  } Completion0;

  typedef struct packed {
    logic [31:0] rsvd_hi;
    BusID        reqID;
    logic [7:0]  tag;
    logic        rsvd_la;
    logic [6:0]  lowerAddr;
  } Completion1;

  typedef struct packed {
    BusID       reqID;
    logic [7:0] tag;
    logic [3:0] lastBE;
    logic [3:0] firstBE;
    HdrDw0      dw0;
  } RdReq0;

  typedef struct packed {
    logic [31:0] rsvd_hi;
    logic [24:0] addr;
    logic [6:0]  rsvd_lo;
  } RdReq1;

  function automatic HdrDw0 mk_dw0(input logic [2:0] fmt, input logic [4:0] typ,
                                   input logic [9:0] len);
    HdrDw0 h;
    h           = '0;
    h.fmt       = fmt;
    h.typ       = typ;
    h.length    = len;
    return h;
  endfunction

endpackage

// File: rtl/tlp_send.sv
// tlp_send: transmit-side TLP engine.
//   Inputs : pcieClk_in/pcieRst_in (sync, active-high), cfgBusID_in,
//            action stream (actData_in/actValid_in), register read data
//            (cpuRdData_in), DMA request (dmaReqAddr_in/dmaReqValid_in),
//            TX backpressure (txReady_in).
//   Outputs: actReady_out, register strobes (cpuChan_out, cpuWrData_out,
//            cpuWrValid_out, cpuRdValid_out), dmaReqReady_out and the
//            Avalon-ST TX beat (txData_out, txValid_out, txSOP_out, txEOP_out).
// REG_READ -> 3-beat CplD, REG_WRITE -> one-cycle strobe, DMA -> 2-beat MRd.
module tlp_send
  import tlp_xcvr_pkg::*;
(
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  BusID        cfgBusID_in,
  input  Action       actData_in,
  input  logic        actValid_in,
  output logic        actReady_out,
  output ExtChan      cpuChan_out,
  output logic [31:0] cpuWrData_out,
  output logic        cpuWrValid_out,
  output logic        cpuRdValid_out,
  input  logic [31:0] cpuRdData_in,
  input  logic [31:0] dmaReqAddr_in,
  input  logic        dmaReqValid_in,
  output logic        dmaReqReady_out,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  output logic        txSOP_out,
  output logic        txEOP_out,
  input  logic        txReady_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDWAIT, S_CPL0, S_CPL1, S_CPL2, S_DMA0, S_DMA1
  } State;

  State        r_state;
  BusID        r_reqID;
  logic [7:0]  r_tag;
  ExtChan      r_chan;
  logic [31:0] r_rdData;
  logic [24:0] r_dmaAddr;

  logic       w_idle;
  Completion0 w_cpl0;
  Completion1 w_cpl1;
  RdReq0      w_rd0;
  RdReq1      w_rd1;

  assign w_idle = (r_state == S_IDLE);

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Actions win over DMA; writes and unknown kinds stay in IDLE.
          if (actValid_in) begin
            if (actData_in.kind == REG_READ) begin
              r_reqID <= actData_in.reqID;
              r_tag   <= actData_in.tag;
              r_chan  <= actData_in.chan;
              r_state <= S_RDWAIT;
            end
          end else if (dmaReqValid_in) begin
            r_dmaAddr <= dmaReqAddr_in[31:7];
            r_state   <= S_DMA0;
          end
        end
        S_RDWAIT: begin
          r_rdData <= cpuRdData_in;
          r_state  <= S_CPL0;
        end
        S_CPL0: if (txReady_in) r_state <= S_CPL1;
        S_CPL1: if (txReady_in) r_state <= S_CPL2;
        S_CPL2: if (txReady_in) r_state <= S_IDLE;
        S_DMA0: if (txReady_in) r_state <= S_DMA1;
        S_DMA1: if (txReady_in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Header beats are built from latched fields, so they stay stable while
  // the core stalls us.
  always_comb begin
    w_cpl0             = '0;
    w_cpl0.dw0         = mk_dw0(FMT_H3DW_WITHDATA, TYP_COMPLETION, 10'd1);
    w_cpl0.completerID = cfgBusID_in;
    w_cpl0.byteCount   = 12'd4;

    w_cpl1             = '0;
    w_cpl1.reqID       = r_reqID;
    w_cpl1.tag         = r_tag;
    w_cpl1.lowerAddr   = {r_chan, 3'b000};  // 8-byte register stride

    w_rd0              = '0;
    w_rd0.dw0          = mk_dw0(FMT_H3DW_NODATA, TYP_MEM_RW_REQ, DMA_LEN_DW);
    w_rd0.reqID        = cfgBusID_in;
    w_rd0.lastBE       = 4'hF;
    w_rd0.firstBE      = 4'hF;

    w_rd1              = '0;
    w_rd1.addr         = r_dmaAddr;
  end

  always_comb begin
    actReady_out    = w_idle;
    dmaReqReady_out = w_idle && !actValid_in;
    cpuChan_out     = w_idle ? actData_in.chan : r_chan;
    cpuWrData_out   = actData_in.data;
    cpuWrValid_out  = w_idle && actValid_in && (actData_in.kind == REG_WRITE);
    cpuRdValid_out  = w_idle && actValid_in && (actData_in.kind == REG_READ);

    txValid_out = 1'b0;
    txSOP_out   = 1'b0;
    txEOP_out   = 1'b0;
    txData_out  = '0;
    case (r_state)
      S_CPL0: begin txValid_out = 1'b1; txSOP_out = 1'b1; txData_out = w_cpl0; end
      S_CPL1: begin txValid_out = 1'b1; txData_out = w_cpl1; end
      S_CPL2: begin txValid_out = 1'b1; txEOP_out = 1'b1; txData_out = {32'h0, r_rdData}; end
      S_DMA0: begin txValid_out = 1'b1; txSOP_out = 1'b1; txData_out = w_rd0; end
      S_DMA1: begin txValid_out = 1'b1; txEOP_out = 1'b1; txData_out = w_rd1; end
      default: ;
    endcase
  end

endmodule
